// File: rtl/i2c_slave_ctrl_if.sv
// I2C slave sequencer bus bundle.
// Timer/detector/FIFO side is master, sequencer is slave.
interface i2c_slave_ctrl_if #(
  parameter int CNT_BITS = 8
) ();
  logic                start_found;
  logic                stop_found;
  logic                byte_received;
  logic                ack_prep;
  logic                check_ack;
  logic                ack_done;
  logic                address_match;
  logic                rw_mode;
  logic                sda_in;
  logic                tx_empty;
  logic                rx_full;
  logic                rx_enable;
  logic                tx_enable;
  logic                load_data;
  logic                tx_pop;
  logic                rx_push;
  logic [1:0]          sda_mode;
  logic                busy;
  logic [CNT_BITS-1:0] byte_count;
  logic                underrun;
  logic                overrun;

  modport master (
    output start_found, stop_found, byte_received,
    output ack_prep, check_ack, ack_done,
    output address_match, rw_mode, sda_in,
    output tx_empty, rx_full,
    input  rx_enable, tx_enable, load_data,
    input  tx_pop, rx_push, sda_mode, busy,
    input  byte_count, underrun, overrun
  );

  modport slave (
    input  start_found, stop_found, byte_received,
    input  ack_prep, check_ack, ack_done,
    input  address_match, rw_mode, sda_in,
    input  tx_empty, rx_full,
    output rx_enable, tx_enable, load_data,
    output tx_pop, rx_push, sda_mode, busy,
    output byte_count, underrun, overrun
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction sequencer.
// Drives shifters, SDA mode and FIFO strobes.
module i2c_slave_ctrl #(
  parameter int CNT_BITS     = 8,
  parameter bit NACK_ON_FULL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  i2c_slave_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_CHK  = 4'd2,
    S_ADDR_ACK  = 4'd3,
    S_ADDR_NACK = 4'd4,
    S_LOAD      = 4'd5,
    S_TX        = 4'd6,
    S_TX_ACK    = 4'd7,
    S_RX        = 4'd8,
    S_RX_PUSH   = 4'd9,
    S_RX_ACK    = 4'd10,
    S_WAIT_STOP = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                r_rw_q;
  logic                r_mack_q;
  logic                r_mack_seen;
  logic                r_nack_q;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_underrun;
  logic                r_overrun;

  logic                w_clr;
  logic                w_inc;
  logic                w_cnt_max;

  // ack_prep is implied by the ACK states; unused here
  logic                w_unused;
  assign w_unused = bus.ack_prep;

  assign w_clr     = bus.start_found;
  assign w_cnt_max = (r_cnt == {CNT_BITS{1'b1}});
  assign w_inc     = ((r_state == S_TX) && bus.byte_received)
                   || (r_state == S_RX_PUSH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: START beats STOP, both beat per-state rules
  always_comb begin
    w_next = r_state;
    if (bus.start_found) begin
      w_next = S_ADDR;
    end else if (bus.stop_found) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      w_next = S_IDLE;
        S_ADDR:
          if (bus.byte_received) w_next = S_ADDR_CHK;
        S_ADDR_CHK:
          w_next = bus.address_match ? S_ADDR_ACK
                                     : S_ADDR_NACK;
        S_ADDR_ACK:
          if (bus.ack_done)
            w_next = r_rw_q ? S_LOAD : S_RX;
        S_ADDR_NACK:
          if (bus.ack_done) w_next = S_IDLE;
        S_LOAD:      w_next = S_TX;
        S_TX:
          if (bus.byte_received) w_next = S_TX_ACK;
        S_TX_ACK:
          if (bus.ack_done)
            w_next = r_mack_q ? S_WAIT_STOP : S_LOAD;
        S_RX:
          if (bus.byte_received) w_next = S_RX_PUSH;
        S_RX_PUSH:   w_next = S_RX_ACK;
        S_RX_ACK:
          if (bus.ack_done) w_next = S_RX;
        S_WAIT_STOP: w_next = S_WAIT_STOP;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // Moore output decode; tx_pop also gated by FIFO state
  always_comb begin
    bus.rx_enable = 1'b0;
    bus.tx_enable = 1'b0;
    bus.load_data = 1'b0;
    bus.tx_pop    = 1'b0;
    bus.rx_push   = 1'b0;
    bus.sda_mode  = 2'b00;
    bus.busy      = (r_state != S_IDLE);
    unique case (r_state)
      S_ADDR:     bus.rx_enable = 1'b1;
      S_ADDR_ACK: bus.sda_mode  = 2'b01;
      S_LOAD: begin
        bus.load_data = 1'b1;
        bus.tx_pop    = ~bus.tx_empty;
        bus.sda_mode  = 2'b11;
      end
      S_TX: begin
        bus.tx_enable = 1'b1;
        bus.sda_mode  = 2'b11;
      end
      S_RX:       bus.rx_enable = 1'b1;
      S_RX_PUSH:  bus.rx_push   = ~bus.rx_full;
      S_RX_ACK:
        bus.sda_mode = r_nack_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Direction bit latched while the address is checked
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rw_q <= 1'b0;
    else if (r_state == S_ADDR_CHK)
      r_rw_q <= bus.rw_mode;
  end

  // Master ACK taken on the first check_ack cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mack_q    <= 1'b0;
      r_mack_seen <= 1'b0;
    end else if (r_state != S_TX_ACK) begin
      r_mack_seen <= 1'b0;
    end else if (bus.check_ack && !r_mack_seen) begin
      r_mack_q    <= bus.sda_in;
      r_mack_seen <= 1'b1;
    end
  end

  // Write-byte ACK/NACK decision made at push time
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_nack_q <= 1'b0;
    else if (r_state == S_RX_PUSH)
      r_nack_q <= bus.rx_full ? NACK_ON_FULL : 1'b0;
  end

  // Saturating data byte counter, cleared by START
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_clr)
      r_cnt <= '0;
    else if (w_inc && !w_cnt_max)
      r_cnt <= r_cnt + CNT_BITS'(1);
  end

  // Sticky error flags, cleared by START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_clr) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if ((r_state == S_LOAD) && bus.tx_empty)
        r_underrun <= 1'b1;
      if ((r_state == S_RX_PUSH) && bus.rx_full)
        r_overrun <= 1'b1;
    end
  end

  assign bus.byte_count = r_cnt;
  assign bus.underrun   = r_underrun;
  assign bus.overrun    = r_overrun;

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
Top-level sequencer for the I2C slave receive/transmit path. It consumes the bit-timer events (byte_received, ack_prep, check_ack, ack_done) and the edge/start/stop detector outputs. From these it drives the shift-register enables, the SDA output mode select, and the TX/RX FIFO handshakes. It also keeps per-transaction byte counts and sticky error flags for the host-side status register.

Parameters:
CNT_BITS, 8, width of the per-transaction byte counter (saturating)
NACK_ON_FULL, 1, 1 = NACK a write byte when the RX FIFO is full; 0 = ACK it and drop the byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start_found  in  1  1-cycle pulse, START or repeated START detected
stop_found  in  1  1-cycle pulse, STOP detected
byte_received  in  1  1-cycle pulse from the timer, 8 bits shifted
ack_prep  in  1  timer level, slave-ACK drive window open
check_ack  in  1  timer level, master-ACK sample window
ack_done  in  1  timer level, ACK bit complete (1 cycle)
address_match  in  1  received address byte matches the slave address
rw_mode  in  1  R/W bit of the address byte (1 = master read)
sda_in  in  1  synchronized SDA
tx_empty  in  1  TX FIFO empty
rx_full  in  1  RX FIFO full
rx_enable  out  1  RX shift register shift enable
tx_enable  out  1  TX shift register shift enable
load_data  out  1  load the TX shift register from the FIFO head (1 cycle)
tx_pop  out  1  TX FIFO read strobe (1 cycle)
rx_push  out  1  RX FIFO write strobe (1 cycle)
sda_mode  out  2  00 release, 01 drive low (ACK), 10 drive high (NACK), 11 drive TX shift bit
busy  out  1  high in every state except IDLE
byte_count  out  CNT_BITS  data bytes transferred since the last START, address byte excluded, saturates at all-ones
underrun  out  1  sticky: a read load occurred while tx_empty
overrun  out  1  sticky: a write byte arrived while rx_full

Behaviour:
- Reset: state IDLE; all outputs 0; byte_count 0.
- Outputs are Moore decodes of the state, except where marked as registered.
- Global rules, evaluated before the per-state rules:
  - stop_found in any state -> IDLE.
  - start_found in any state -> ADDR.
  - If both occur in the same cycle, start_found wins.
  - Entering ADDR through start_found clears byte_count, underrun and overrun on the next edge.
- States:
  - IDLE: all outputs 0; waits for start_found.
  - ADDR: rx_enable=1; byte_received -> ADDR_CHK.
  - ADDR_CHK: lasts 1 cycle. Latches rw_mode into rw_q. address_match=1 -> ADDR_ACK, else -> ADDR_NACK.
  - ADDR_ACK: sda_mode=01; ack_done -> LOAD if rw_q=1, else RX.
  - ADDR_NACK: sda_mode=00 (release, so the master sees NACK via the pull-up); ack_done -> IDLE.
  - LOAD: lasts 1 cycle. load_data=1 and sda_mode=11. tx_pop=1 only if tx_empty=0. If tx_empty=1, the shifter loads 0xFF and underrun sets. Next state TX.
  - TX: tx_enable=1, sda_mode=11; byte_received -> TX_ACK and byte_count increments.
  - TX_ACK: sda_mode=00. On the first cycle with check_ack=1, sample sda_in into mack_q. ack_done -> LOAD if mack_q=0, else WAIT_STOP.
  - RX: rx_enable=1; byte_received -> RX_PUSH.
  - RX_PUSH: lasts 1 cycle; byte_count increments.
    - rx_full=0: rx_push=1, nack_q=0.
    - rx_full=1: overrun sets, no push, nack_q=NACK_ON_FULL.
    - Next state RX_ACK.
  - RX_ACK: sda_mode = nack_q ? 10 : 01; ack_done -> RX.
  - WAIT_STOP: all outputs 0 except busy; exits only via the global stop/start rules.
- byte_count saturates at 2^CNT_BITS-1; it never wraps.
- underrun and overrun hold until the next START or reset.
- Latency: the event pulse is sampled at edge N, the new state's outputs are valid after edge N, and strobes last exactly 1 cycle.
- Reset mid-transfer aborts immediately; no strobe is issued.

Test Plan:
- Write transaction: START, address byte with address_match=1 and rw_mode=0, then 3 data bytes with rx_full=0, then STOP.
  - Required: sda_mode=01 during each of the 4 ACK windows.
  - Required: 3 rx_push pulses, each the cycle after byte_received.
  - Required: byte_count=3; busy falls the cycle after stop_found.
- Read transaction: address byte with rw_mode=1 and a 2-entry TX FIFO; master ACKs byte 1 (sda_in=0 at check_ack) and NACKs byte 2.
  - Required: load_data and tx_pop pulse twice; sda_mode=11 during TX.
  - Required: after byte 2 the block sits in WAIT_STOP with sda_mode=00, and byte_count=2.
- Address mismatch: address_match=0.
  - Required: sda_mode=00 through the ACK window, no rx_enable after ack_done, and state returns to IDLE.
- Overflow: rx_full=1 on the 2nd write byte with NACK_ON_FULL=1.
  - Required: no rx_push, sda_mode=10 in that ACK window, overrun=1.
  - Required: overrun clears on the next start_found.
- Underrun plus repeated START: read with tx_empty=1.
  - Required: load_data=1 with tx_pop=0, underrun=1.
  - Then start_found mid-TX -> ADDR next cycle, with byte_count and underrun cleared.
- Simultaneous start_found and stop_found in RX -> ADDR. Then assert rst mid-LOAD -> all outputs 0 immediately (asynchronously).
